// File: rtl/indptr_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// indptr_buffer_ctrl
//
// Ping-pong controller for a two-bank CSR row-pointer (indptr) buffer.
// One bank is filled by the loader while the other serves row-range lookups.
// The banks swap roles when the loader completes a block and the consumer has
// released the bank it was reading.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   ld_valid/ld_ready/ld_data    loader stream, K+1 words per block
//   lk_valid/lk_ready/lk_row     lookup request for row r
//   res_valid/res_start/res_end/res_err
//                            lookup result RD_LAT cycles after accept
//                            (indptr[r], indptr[r+1]); err when r >= K
//   rel                      consumer release of the read bank
//   bank_full, fill_sel, rd_sel  bank role / status
//   enable*, writeEnable*, addressport*, writeport*, readport*
//                            two-bank, two-port buffer interface
//
// Handshakes: a transfer happens in a cycle where valid and ready are both
// high; ready never depends on valid, and result outputs have no
// backpressure (res_valid is a one-cycle strobe per accepted lookup).
// ---------------------------------------------------------------------------
module indptr_buffer_ctrl #(
  parameter int K      = 1024,
  parameter int ADDR_W = $clog2(K + 1),
  parameter int DATA_W = $clog2(K * K / 32),
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              lk_valid,
  output logic              lk_ready,
  input  logic [ADDR_W-1:0] lk_row,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_start,
  output logic [DATA_W-1:0] res_end,
  output logic              res_err,
  input  logic              rel,
  output logic [1:0]        bank_full,
  output logic              fill_sel,
  output logic              rd_sel,
  output logic              enableA,
  output logic              enableB,
  output logic              writeEnableA1,
  output logic              writeEnableA2,
  output logic              writeEnableB1,
  output logic              writeEnableB2,
  output logic [ADDR_W-1:0] addressportA1,
  output logic [ADDR_W-1:0] addressportA2,
  output logic [ADDR_W-1:0] addressportB1,
  output logic [ADDR_W-1:0] addressportB2,
  output logic [DATA_W-1:0] writeportA1,
  output logic [DATA_W-1:0] writeportA2,
  output logic [DATA_W-1:0] writeportB1,
  output logic [DATA_W-1:0] writeportB2,
  input  logic [DATA_W-1:0] readportA1,
  input  logic [DATA_W-1:0] readportA2,
  input  logic [DATA_W-1:0] readportB1,
  input  logic [DATA_W-1:0] readportB2
);

  localparam int                INF_W = $clog2(RD_LAT + 2);
  localparam logic [ADDR_W-1:0] K_A   = ADDR_W'(K);

  // State
  logic [1:0]        bank_full_q, bank_full_d;
  logic              fill_sel_q, fill_sel_d;
  logic              rd_sel_q, rd_sel_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [INF_W-1:0]  inflight_q, inflight_d;
  logic              rel_pending_q, rel_pending_d;
  logic              init_q;
  logic [RD_LAT-1:0] vld_pipe_q, vld_pipe_d;
  logic [RD_LAT-1:0] sel_pipe_q, sel_pipe_d;
  logic [RD_LAT-1:0] err_pipe_q, err_pipe_d;

  // Handshake / event decode
  logic              wr_fire;
  logic              lk_fire;
  logic              row_err;
  logic              swap;
  logic [ADDR_W-1:0] rd_addr1, rd_addr2;
  logic              res_sel, res_is_err;

  // init_q holds ld_ready low during the cycle right after reset release so
  // every output reads 0 while reset is being applied.
  assign ld_ready = init_q & ~bank_full_q[fill_sel_q];
  assign lk_ready = bank_full_q[rd_sel_q] & ~rel_pending_q & ~rel;

  assign wr_fire  = ld_valid & ld_ready;
  assign lk_fire  = lk_valid & lk_ready;
  assign row_err  = (lk_row >= K_A);
  assign swap     = rel_pending_q & (inflight_q == '0);

  // Out-of-range rows read address 0; the error flag zeroes the data later.
  assign rd_addr1 = row_err ? '0 : lk_row;
  assign rd_addr2 = row_err ? '0 : lk_row + ADDR_W'(1);

  assign bank_full = bank_full_q;
  assign fill_sel  = fill_sel_q;
  assign rd_sel    = rd_sel_q;

  // Next-state logic
  always_comb begin
    bank_full_d   = bank_full_q;
    fill_sel_d    = fill_sel_q;
    rd_sel_d      = rd_sel_q;
    wr_cnt_d      = wr_cnt_q;
    rel_pending_d = rel_pending_q;
    inflight_d    = inflight_q + INF_W'(lk_fire) - INF_W'(vld_pipe_q[RD_LAT-1]);

    if (wr_fire) begin
      if (wr_cnt_q == K_A) begin
        bank_full_d[fill_sel_q] = 1'b1;
        fill_sel_d              = ~fill_sel_q;
        wr_cnt_d                = '0;
      end else begin
        wr_cnt_d = wr_cnt_q + ADDR_W'(1);
      end
    end

    // Fill only ever targets an empty bank and release only a full one, so
    // the two bank_full updates never touch the same bit. A rel arriving in
    // the swap cycle refers to the bank already being released.
    if (swap) begin
      bank_full_d[rd_sel_q] = 1'b0;
      rd_sel_d              = ~rd_sel_q;
      rel_pending_d         = 1'b0;
    end else if (rel && bank_full_q[rd_sel_q]) begin
      rel_pending_d = 1'b1;
    end

    // Valid, bank select and error flag travel together down the pipeline.
    vld_pipe_d    = '0;
    sel_pipe_d    = '0;
    err_pipe_d    = '0;
    vld_pipe_d[0] = lk_fire;
    sel_pipe_d[0] = rd_sel_q;
    err_pipe_d[0] = row_err;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      sel_pipe_d[i] = sel_pipe_q[i-1];
      err_pipe_d[i] = err_pipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_full_q   <= '0;
      fill_sel_q    <= 1'b0;
      rd_sel_q      <= 1'b0;
      wr_cnt_q      <= '0;
      inflight_q    <= '0;
      rel_pending_q <= 1'b0;
      init_q        <= 1'b0;
      vld_pipe_q    <= '0;
      sel_pipe_q    <= '0;
      err_pipe_q    <= '0;
    end else begin
      bank_full_q   <= bank_full_d;
      fill_sel_q    <= fill_sel_d;
      rd_sel_q      <= rd_sel_d;
      wr_cnt_q      <= wr_cnt_d;
      inflight_q    <= inflight_d;
      rel_pending_q <= rel_pending_d;
      init_q        <= 1'b1;
      vld_pipe_q    <= vld_pipe_d;
      sel_pipe_q    <= sel_pipe_d;
      err_pipe_q    <= err_pipe_d;
    end
  end

  // Buffer port drive. A bank is either being filled or being read in a
  // given cycle, never both, so the two branches cannot collide.
  always_comb begin
    enableA       = 1'b0;
    enableB       = 1'b0;
    writeEnableA1 = 1'b0;
    writeEnableA2 = 1'b0;
    writeEnableB1 = 1'b0;
    writeEnableB2 = 1'b0;
    addressportA1 = '0;
    addressportA2 = '0;
    addressportB1 = '0;
    addressportB2 = '0;
    writeportA1   = '0;
    writeportA2   = '0;
    writeportB1   = '0;
    writeportB2   = '0;

    if (wr_fire) begin
      if (!fill_sel_q) begin
        enableA       = 1'b1;
        writeEnableA1 = 1'b1;
        addressportA1 = wr_cnt_q;
        writeportA1   = ld_data;
      end else begin
        enableB       = 1'b1;
        writeEnableB1 = 1'b1;
        addressportB1 = wr_cnt_q;
        writeportB1   = ld_data;
      end
    end

    if (lk_fire) begin
      if (!rd_sel_q) begin
        enableA       = 1'b1;
        addressportA1 = rd_addr1;
        addressportA2 = rd_addr2;
      end else begin
        enableB       = 1'b1;
        addressportB1 = rd_addr1;
        addressportB2 = rd_addr2;
      end
    end
  end

  // Result stage
  assign res_sel    = sel_pipe_q[RD_LAT-1];
  assign res_is_err = err_pipe_q[RD_LAT-1];
  assign res_valid  = vld_pipe_q[RD_LAT-1];
  assign res_err    = res_valid & res_is_err;

  always_comb begin
    res_start = '0;
    res_end   = '0;
    if (res_valid && !res_is_err) begin
      res_start = res_sel ? readportB1 : readportA1;
      res_end   = res_sel ? readportB2 : readportA2;
    end
  end

endmodule

// File: tb/tb_indptr_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for indptr_buffer_ctrl: emulates the two-bank buffer with a
// RD_LAT read pipeline, runs directed sequences and a table of lookups, then
// random traffic scored against a block-level model of the double buffer.
// ---------------------------------------------------------------------------
module tb_indptr_buffer_ctrl;
  localparam int K      = 1024;
  localparam int ADDR_W = $clog2(K + 1);
  localparam int DATA_W = $clog2(K * K / 32);
  localparam int RD_LAT = 2;
  localparam int EXP_W  = 32 + 1 + 2 * DATA_W;
  localparam int NB     = 6;
  localparam logic [ADDR_W-1:0] K_A = ADDR_W'(K);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic              ld_valid = 1'b0, ld_ready;
  logic [DATA_W-1:0] ld_data = '0;
  logic              lk_valid = 1'b0, lk_ready;
  logic [ADDR_W-1:0] lk_row = '0;
  logic              res_valid, res_err;
  logic [DATA_W-1:0] res_start, res_end;
  logic              rel = 1'b0;
  logic [1:0]        bank_full;
  logic              fill_sel, rd_sel;
  logic              enableA, enableB;
  logic              writeEnableA1, writeEnableA2, writeEnableB1, writeEnableB2;
  logic [ADDR_W-1:0] addressportA1, addressportA2, addressportB1, addressportB2;
  logic [DATA_W-1:0] writeportA1, writeportA2, writeportB1, writeportB2;
  logic [DATA_W-1:0] readportA1, readportA2, readportB1, readportB2;

  indptr_buffer_ctrl #(.K(K), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_row(lk_row),
    .res_valid(res_valid), .res_start(res_start), .res_end(res_end), .res_err(res_err),
    .rel(rel), .bank_full(bank_full), .fill_sel(fill_sel), .rd_sel(rd_sel),
    .enableA(enableA), .enableB(enableB),
    .writeEnableA1(writeEnableA1), .writeEnableA2(writeEnableA2),
    .writeEnableB1(writeEnableB1), .writeEnableB2(writeEnableB2),
    .addressportA1(addressportA1), .addressportA2(addressportA2),
    .addressportB1(addressportB1), .addressportB2(addressportB2),
    .writeportA1(writeportA1), .writeportA2(writeportA2),
    .writeportB1(writeportB1), .writeportB2(writeportB2),
    .readportA1(readportA1), .readportA2(readportA2),
    .readportB1(readportB1), .readportB2(readportB2)
  );

  // ---------------- buffer emulation (2-cycle read) ----------------
  logic [DATA_W-1:0] mem_a [0:K];
  logic [DATA_W-1:0] mem_b [0:K];
  logic [ADDR_W-1:0] a1_q = '0, a2_q = '0, b1_q = '0, b2_q = '0;

  always @(posedge clk) begin
    if (enableA) begin
      if (writeEnableA1 && addressportA1 <= K_A) mem_a[addressportA1] <= writeportA1;
      a1_q <= addressportA1;
      a2_q <= addressportA2;
    end
    if (enableB) begin
      if (writeEnableB1 && addressportB1 <= K_A) mem_b[addressportB1] <= writeportB1;
      b1_q <= addressportB1;
      b2_q <= addressportB2;
    end
    readportA1 <= (a1_q <= K_A) ? mem_a[a1_q] : '0;
    readportA2 <= (a2_q <= K_A) ? mem_a[a2_q] : '0;
    readportB1 <= (b1_q <= K_A) ? mem_b[b1_q] : '0;
    readportB2 <= (b2_q <= K_A) ? mem_b[b2_q] : '0;
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic push_exp(input int due, input logic err,
                          input logic [DATA_W-1:0] s, input logic [DATA_W-1:0] e);
    exp_q.push_back({32'(due), err, s, e});
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (exp_q.size() > 0 && int'(exp_q[0][EXP_W-1 -: 32]) == cyc) begin
        mon_e = exp_q.pop_front();
        check("res_valid", res_valid, 1);
        check("res_err",   res_err,   mon_e[2*DATA_W]);
        check("res_start", res_start, mon_e[2*DATA_W-1 -: DATA_W]);
        check("res_end",   res_end,   mon_e[DATA_W-1:0]);
      end else begin
        check("res_idle", res_valid, 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; ld_valid = 1'b0; lk_valid = 1'b0; rel = 1'b0;
    exp_q.delete();
    repeat (n) nxt();
    rst = 1'b0;
    nxt();
  endtask

  // Stream one full block of mult*i into `bank`; for the first lk_cycles
  // words also issue lookups on the read bank, whose content is rd_mult*i.
  task automatic fill_block(input int mult, input bit bank, input int lk_cycles, input int rd_mult);
    bit ok;
    int r;
    for (int i = 0; i <= K; i++) begin
      ld_valid = 1'b1;
      ld_data  = DATA_W'(mult * i);
      lk_valid = (i < lk_cycles);
      r        = $urandom_range(K - 1);
      lk_row   = ADDR_W'(r);
      @(negedge clk);
      check("fill_ready", ld_ready, 1);
      if (!bank)
        ok = enableA && writeEnableA1 && !writeEnableA2 && addressportA1 == ADDR_W'(i)
             && writeportA1 == ld_data && !writeEnableB1;
      else
        ok = enableB && writeEnableB1 && !writeEnableB2 && addressportB1 == ADDR_W'(i)
             && writeportB1 == ld_data && !writeEnableA1;
      check("fill_write", ok, 1);
      if (lk_valid) begin
        check("fill_lk_ready", lk_ready, 1);
        if (lk_ready) push_exp(cyc + RD_LAT, 1'b0, DATA_W'(rd_mult * r), DATA_W'(rd_mult * (r + 1)));
      end
      nxt();
    end
    ld_valid = 1'b0;
    lk_valid = 1'b0;
  endtask

  // ---------------- lookup vector table ----------------
  typedef struct {
    logic [ADDR_W-1:0] row;
    logic              err;
    logic [DATA_W-1:0] s;
    logic [DATA_W-1:0] e;
  } lk_vec_t;
  lk_vec_t tbl[8];

  // ---------------- random-phase model ----------------
  logic [DATA_W-1:0] gold [0:NB-1][0:K];
  int blocks_q[$];
  int avail[NB];

  initial begin : main
    bit ok;
    int rows[8];
    int loaded, wcnt, held, rc, post, b, r;
    bit front_rel, elig, lerr;

    // reset state
    rst = 1'b1;
    nxt(); nxt();
    @(negedge clk);
    check("rst_bank_full", bank_full, 0);
    check("rst_ld_ready", ld_ready, 0);
    check("rst_lk_ready", lk_ready, 0);
    check("rst_enables", {enableA, enableB}, 0);
    nxt();
    do_reset(1);

    // Fill bank 0 with 3i and check handoff
    fill_block(3, 1'b0, 0, 0);
    @(negedge clk);
    check("f0_bank_full", bank_full, 2'b01);
    check("f0_fill_sel", fill_sel, 1);
    check("f0_rd_sel", rd_sel, 0);
    check("f0_handoff_lk_ready", lk_ready, 1);
    check("f0_ld_ready", ld_ready, 1);
    nxt();

    // Back-to-back table lookups on bank 0
    rows = '{5, 0, 1, 2, K - 1, K, (1 << ADDR_W) - 1, 100};
    for (int i = 0; i < 8; i++) begin
      tbl[i].row = ADDR_W'(rows[i]);
      tbl[i].err = (rows[i] >= K);
      tbl[i].s   = tbl[i].err ? '0 : DATA_W'(3 * rows[i]);
      tbl[i].e   = tbl[i].err ? '0 : DATA_W'(3 * (rows[i] + 1));
    end
    for (int i = 0; i < 8; i++) begin
      lk_valid = 1'b1;
      lk_row   = tbl[i].row;
      @(negedge clk);
      check("tbl_accept", lk_ready, 1);
      if (lk_ready) push_exp(cyc + RD_LAT, tbl[i].err, tbl[i].s, tbl[i].e);
      nxt();
    end
    lk_valid = 1'b0;
    repeat (RD_LAT + 2) nxt();
    check("tbl_drain", exp_q.size(), 0);

    // Fill bank 1 with 7i while bank 0 serves lookups
    fill_block(7, 1'b1, 64, 3);
    @(negedge clk);
    check("f1_bank_full", bank_full, 2'b11);
    check("f1_fill_sel", fill_sel, 0);
    check("f1_ld_ready", ld_ready, 0);
    nxt();

    // Both full: loader stalls with no writes
    ld_valid = 1'b1;
    ld_data  = DATA_W'(12'h1ab);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_ld_ready", ld_ready, 0);
      check("stall_no_we", writeEnableA1 | writeEnableB1, 0);
      nxt();
    end

    // Two lookups in flight, then release
    for (int i = 0; i < 2; i++) begin
      lk_valid = 1'b1;
      lk_row   = ADDR_W'(10 + i);
      @(negedge clk);
      check("rel_pre_accept", lk_ready, 1);
      if (lk_ready) push_exp(cyc + RD_LAT, 1'b0, DATA_W'(3 * (10 + i)), DATA_W'(3 * (11 + i)));
      nxt();
    end
    lk_valid = 1'b0;
    rel      = 1'b1;
    @(negedge clk);
    check("rel_blocks_lk", lk_ready, 0);
    nxt();
    rel = 1'b0;
    @(negedge clk);
    check("rel_wait1_rd_sel", rd_sel, 0);
    nxt();
    @(negedge clk);
    check("rel_wait2_rd_sel", rd_sel, 0);
    check("rel_wait2_full", bank_full, 2'b11);
    nxt();
    lk_valid = 1'b1;
    lk_row   = ADDR_W'(1);
    @(negedge clk);
    check("swap_rd_sel", rd_sel, 1);
    check("swap_bank_full", bank_full, 2'b10);
    check("swap_ld_ready", ld_ready, 1);
    ok = enableA && writeEnableA1 && addressportA1 == '0 && writeportA1 == DATA_W'(12'h1ab);
    check("swap_write_a0", ok, 1);
    check("swap_lk_ready", lk_ready, 1);
    ok = enableB && addressportB1 == ADDR_W'(1) && addressportB2 == ADDR_W'(2)
         && !writeEnableB1 && !writeEnableB2;
    check("swap_lookup_b", ok, 1);
    if (lk_ready) push_exp(cyc + RD_LAT, 1'b0, DATA_W'(7), DATA_W'(14));
    nxt();
    lk_valid = 1'b0;

    // 99 more words (100 in total), then reset mid-fill
    for (int i = 1; i < 100; i++) begin
      ld_data = DATA_W'(5 * i);
      @(negedge clk);
      check("part_ld_ready", ld_ready, 1);
      nxt();
    end
    rst = 1'b1;
    exp_q.delete();
    nxt();
    @(negedge clk);
    check("mid_rst_bank_full", bank_full, 0);
    check("mid_rst_sel", {fill_sel, rd_sel}, 0);
    check("mid_rst_ready", {ld_ready, lk_ready}, 0);
    check("mid_rst_quiet", {res_valid, enableA, enableB}, 0);
    nxt();
    rst      = 1'b0;
    ld_valid = 1'b0;
    nxt();
    ld_valid = 1'b1;
    ld_data  = DATA_W'(8'h55);
    @(negedge clk);
    check("post_rst_ld_ready", ld_ready, 1);
    check("post_rst_full_sel", {bank_full, fill_sel}, 0);
    ok = enableA && writeEnableA1 && addressportA1 == '0 && writeportA1 == DATA_W'(8'h55)
         && !writeEnableB1;
    check("post_rst_write_a0", ok, 1);
    nxt();
    ld_valid = 1'b0;

    // ---------------- random phase ----------------
    for (int bb = 0; bb < NB; bb++)
      for (int i = 0; i <= K; i++) gold[bb][i] = DATA_W'($urandom);
    do_reset(2);
    loaded = 0; wcnt = 0; front_rel = 1'b0; rc = 0; post = 0;
    blocks_q.delete();
    while (rc < 40000 && !(loaded == NB && post >= 200)) begin
      ld_valid = (loaded < NB) && ($urandom_range(3) != 0);
      ld_data  = (loaded < NB) ? gold[loaded][wcnt] : '0;
      lk_valid = $urandom_range(1);
      r        = ($urandom_range(9) != 0) ? $urandom_range(K - 1) : $urandom_range((1 << ADDR_W) - 1, K);
      lk_row   = ADDR_W'(r);
      elig     = blocks_q.size() > 0 && !front_rel && avail[blocks_q[0]] <= cyc;
      rel      = elig && ($urandom_range(31) == 0);
      @(negedge clk);
      held = blocks_q.size();
      if (!(held == 2 && front_rel)) check("rnd_ld_ready", ld_ready, held < 2);
      if (held == 0) check("rnd_lk_ready_none", lk_ready, 0);
      else if (!front_rel && avail[blocks_q[0]] <= cyc) check("rnd_lk_ready", lk_ready, !rel);
      if (rel) front_rel = 1'b1;
      if (lk_valid && lk_ready) begin
        if (front_rel) begin
          void'(blocks_q.pop_front());
          front_rel = 1'b0;
        end
        check("rnd_accept_has_block", blocks_q.size() > 0, 1);
        if (blocks_q.size() > 0) begin
          b    = blocks_q[0];
          lerr = (r >= K);
          push_exp(cyc + RD_LAT, lerr, lerr ? '0 : gold[b][r], lerr ? '0 : gold[b][r + 1]);
        end
      end
      if (ld_valid && ld_ready) begin
        wcnt++;
        if (wcnt == K + 1) begin
          blocks_q.push_back(loaded);
          avail[loaded] = cyc + 1;
          loaded++;
          wcnt = 0;
        end
      end
      if (loaded == NB) post++;
      rc++;
      nxt();
    end
    ld_valid = 1'b0; lk_valid = 1'b0; rel = 1'b0;
    check("rnd_no_timeout", rc < 40000, 1);
    check("rnd_blocks_loaded", loaded, NB);
    repeat (RD_LAT + 2) nxt();
    check("rnd_drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/indptr_buffer_ctrl.md
Name: indptr_buffer_ctrl

Overview:
- Ping-pong controller for the two-bank CSR row-pointer (indptr) double buffer.
- Streams one block's K+1 indptr words from the loader into the empty bank (fill side).
- Serves row-range lookups (indptr[r], indptr[r+1]) from the full bank through both read ports in one cycle (read side).
- Swaps bank roles on loader completion and consumer release, so loading block n+1 overlaps processing block n.

Parameters:
K, 1024, block size; each bank holds K+1 entries
ADDR_W, $clog2(K+1), buffer address width
DATA_W, $clog2(K*K/32), indptr word width
RD_LAT, 2, buffer read latency; result pipeline depth matches it

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ld_valid  in  1  loader word valid
ld_ready  out  1  fill bank empty, word accepted this cycle
ld_data  in  DATA_W  indptr word
lk_valid  in  1  lookup request
lk_ready  out  1  lookup accepted this cycle
lk_row  in  ADDR_W  row index r
res_valid  out  1  result valid (no backpressure)
res_start  out  DATA_W  indptr[r]
res_end  out  DATA_W  indptr[r+1]
res_err  out  1  r >= K; res_start/res_end forced to 0
rel  in  1  consumer release of the read bank
bank_full  out  2  per-bank full flags
fill_sel  out  1  bank currently targeted by the loader
rd_sel  out  1  bank currently served to lookups
enableA, enableB  out  1 each  bank enables to the buffer
writeEnableA1, writeEnableA2, writeEnableB1, writeEnableB2  out  1 each  per-port write enables
addressportA1, addressportA2, addressportB1, addressportB2  out  ADDR_W each  addresses
writeportA1, writeportA2, writeportB1, writeportB2  out  DATA_W each  write data (port 2 data tied 0)
readportA1, readportA2, readportB1, readportB2  in  DATA_W each  read data from the buffer

Behaviour:
- Reset: bank_full=00, fill_sel=0, rd_sel=0, wr_cnt=0, in-flight=0, rel_pending=0.
- Reset: all outputs 0 (ld_ready=1 one cycle after reset release). Memory contents are not cleared. Reset mid-fill or mid-lookup discards all state; in-flight results are dropped.
- Fill:
  - ld_ready = ~bank_full[fill_sel].
  - On ld_valid&ld_ready: write ld_data through port 1 of bank fill_sel at address wr_cnt; assert that bank's enable and writeEnable*1.
  - After the (K+1)th word (wr_cnt==K): next cycle bank_full[fill_sel]=1, fill_sel toggles, wr_cnt=0.
- Lookup:
  - lk_ready = bank_full[rd_sel] & ~rel_pending & ~rel.
  - On accept: port 1 address = r, port 2 address = r+1 of bank rd_sel; enable high, both write enables low.
  - For r >= K: both addresses are driven 0; res_err=1 and data=0 at result time.
  - Results are fully pipelined, one per cycle. res_valid asserts exactly RD_LAT cycles after accept.
  - Data mux select and the err flag travel down the RD_LAT pipeline with each request.
- Release:
  - rel while bank_full[rd_sel]=1 sets rel_pending; rel while not full is ignored.
  - When rel_pending=1 and in-flight count==0, next cycle: bank_full[rd_sel]=0, rd_sel toggles, rel_pending=0.
- Simultaneous events:
  - Fill completion and release on different banks in the same cycle both take effect independently.
  - Bank conflict is impossible: fill only targets an empty bank, reads only target a full bank.
  - Bank enable = OR of its fill write and lookup activity.
- Handoff latency: a freshly filled bank that is also rd_sel accepts lookups 1 cycle after its final write.
- Idle: no write and no lookup implies both enables 0.

Test Plan:
- Fill bank 0 with indptr[i]=3i, i=0..K -> bank_full=01, fill_sel=1; lookup r=5 -> res_valid 2 cycles later, start=15, end=18.
- Back-to-back lookups r=0,1,2 on consecutive cycles -> res_valid 3 consecutive cycles, (0,3),(3,6),(6,9).
- Lookup r=K -> res_err=1, res_start=res_end=0 after 2 cycles.
- Fill bank 1 with 7i while bank 0 serves lookups; rel with 2 lookups in flight -> both results delivered, then rd_sel=1, bank_full=10; lookup r=1 -> (7,14).
- Both banks full -> ld_ready=0, ld_valid held 10 cycles, no write enables; after rel -> ld_ready=1, writes go to bank 0 address 0.
- Assert rst after 100 fill words -> bank_full=00, fill_sel=0, next word written at bank 0 address 0.
